audio_wr_packer: RTL and testbench



---
 rtl/audio_wr_packer_pkg.sv | 22 ++
 rtl/audio_wr_packer_fifo.sv | 67 ++++++
 rtl/audio_wr_packer.sv | 135 +++++++++++++
 tb/tb_audio_wr_packer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_wr_packer_pkg.sv
// Shared constants and width helpers for the audio DDR write path.
package audio_wr_packer_pkg;

    localparam int AUDIO_WIDTH_DEF  = 16;
    localparam int DQ_WIDTH_DEF     = 32;
    localparam int AXI_DATA_WIDTH   = DQ_WIDTH_DEF * 8;
    localparam int SAMPLES_PER_WORD = AXI_DATA_WIDTH / AUDIO_WIDTH_DEF;

    function automatic int axi_data_width(input int dq_width);
        return dq_width * 8;
    endfunction

    function automatic int samples_per_word(input int axi_width, input int audio_width);
        return axi_width / audio_width;
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_wr_packer_fifo.sv
// Single-clock first-word-fall-through FIFO; the stored-word count tells full from empty.
module sync_fifo_fwft
    import audio_wr_packer_pkg::*;
#(
    parameter int WIDTH   = AXI_DATA_WIDTH,
    parameter int DEPTH   = 256,
    parameter int LEVEL_W = level_width(256)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               push_ok, pop_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/audio_wr_packer.sv
// Packs PCM samples into AXI-width words and stages them in a FWFT FIFO for the
// DDR write master, tracking overflow/underflow and dropped-word statistics.
module audio_wr_packer
    import audio_wr_packer_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16,
    parameter int DQ_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 256,
    parameter int LEVEL_WIDTH = 9
) (
    input  logic                   M_AXI_ACLK,
    input  logic                   M_AXI_ARESETN,
    input  logic                   sample_valid,
    input  logic [AUDIO_WIDTH-1:0] sample_data,
    input  logic                   flush,
    input  logic                   wfifo_rd_req,
    output logic [DQ_WIDTH*8-1:0]  wfifo_rd_data,
    output logic [LEVEL_WIDTH-1:0] wfifo_rd_water_level,
    output logic                   overflow,
    output logic                   underflow,
    output logic [15:0]            drop_cnt,
    input  logic                   clr_status
);

    localparam int AXI_W  = axi_data_width(DQ_WIDTH);
    localparam int SPW    = samples_per_word(AXI_W, AUDIO_WIDTH);
    localparam int LANE_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SPW - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [AXI_W-1:0]  shift_q, shift_d;
    logic [AXI_W-1:0]  packed_word;
    logic [AXI_W-1:0]  word_q;
    logic              push_q, push_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [15:0]       drop_q, drop_d;
    logic              fifo_full, fifo_empty;
    logic              drop_evt, unf_evt;

    // The sample lands first; flush then closes whatever word that leaves.
    always_comb begin
        packed_word = shift_q;
        for (int i = 0; i < SPW; i++) begin
            if (sample_valid && lane_q == LANE_W'(i))
                packed_word[i*AUDIO_WIDTH +: AUDIO_WIDTH] = sample_data;
        end
        shift_d = shift_q;
        lane_d  = lane_q;
        push_d  = 1'b0;
        if ((sample_valid && lane_q == LAST_LANE) ||
            (flush && (sample_valid || lane_q != '0))) begin
            push_d  = 1'b1;
            shift_d = '0;
            lane_d  = '0;
        end else if (sample_valid) begin
            shift_d = packed_word;
            lane_d  = lane_q + 1'b1;
        end
    end

    // Cleared shift register gives the zero fill for flushed partial words.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            lane_q  <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (push_d) word_q <= packed_word;
    end

    sync_fifo_fwft #(
        .WIDTH   (AXI_W),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (LEVEL_WIDTH)
    ) u_fifo (
        .clk_i   (M_AXI_ACLK),
        .rst_ni  (M_AXI_ARESETN),
        .push_i  (push_q),
        .pop_i   (wfifo_rd_req),
        .wdata_i (word_q),
        .rdata_o (wfifo_rd_data),
        .level_o (wfifo_rd_water_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign drop_evt = push_q && fifo_full && !wfifo_rd_req;
    assign unf_evt  = wfifo_rd_req && fifo_empty;

    always_comb begin
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        drop_d = drop_q;
        if (clr_status) begin
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            drop_d = '0;
        end else begin
            if (drop_evt) begin
                ovf_d  = 1'b1;
                drop_d = sat_inc16(drop_q);
            end
            if (unf_evt) unf_d = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            drop_q <= drop_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_audio_wr_packer.sv
// Randomised and directed bench for audio_wr_packer with a queue-based reference model.
module tb_audio_wr_packer;

    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sample_valid;
    logic [15:0]  sample_data;
    logic         flush;
    logic         rd_req;
    logic [255:0] rd_data;
    logic [8:0]   level;
    logic         ovf, unf;
    logic [15:0]  dcnt;
    logic         clr;

    audio_wr_packer dut (
        .M_AXI_ACLK           (clk),
        .M_AXI_ARESETN        (rst_n),
        .sample_valid         (sample_valid),
        .sample_data          (sample_data),
        .flush                (flush),
        .wfifo_rd_req         (rd_req),
        .wfifo_rd_data        (rd_data),
        .wfifo_rd_water_level (level),
        .overflow             (ovf),
        .underflow            (unf),
        .drop_cnt             (dcnt),
        .clr_status           (clr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending samples, scoreboard of stored words, status.
    logic [15:0]  m_cur[$];
    logic [255:0] m_fifo[$];
    bit           m_pend_v;
    logic [255:0] m_pend_w;
    bit           m_ovf, m_unf;
    int           m_dcnt;

    // Inputs change 1 time unit after posedge, so at negedge they are what the
    // next posedge will sample, while outputs show the state after the last one.
    always @(negedge clk) begin
        bit           drop;
        logic [255:0] w;
        if (!rst_n) begin
            m_cur.delete();
            m_fifo.delete();
            m_pend_v = 0;
            m_ovf    = 0;
            m_unf    = 0;
            m_dcnt   = 0;
        end
        check("level", 256'(level), 256'(m_fifo.size()));
        check("overflow", 256'(ovf), 256'(m_ovf));
        check("underflow", 256'(unf), 256'(m_unf));
        check("drop_cnt", 256'(dcnt), 256'(m_dcnt));
        if (rst_n) begin
            drop = 0;
            if (rd_req && m_fifo.size() > 0) begin
                check("rd_data", rd_data, m_fifo[0]);
                void'(m_fifo.pop_front());
            end else if (rd_req) begin
                if (!clr) m_unf = 1;
            end
            if (m_pend_v) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pend_w);
                else drop = 1;
            end
            if (clr) begin
                m_ovf  = 0;
                m_unf  = 0;
                m_dcnt = 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_dcnt < 65535) m_dcnt++;
            end
            m_pend_v = 0;
            if (sample_valid) m_cur.push_back(sample_data);
            if (m_cur.size() == 16 || (flush && m_cur.size() > 0)) begin
                w = '0;
                for (int i = 0; i < m_cur.size(); i++) w[i*16 +: 16] = m_cur[i];
                m_pend_v = 1;
                m_pend_w = w;
                m_cur.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sample_valid = 0;
        flush        = 0;
        rd_req       = 0;
        clr          = 0;
    endtask

    task automatic feed(input int n, input bit rnd, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1;
            sample_data  = rnd ? 16'($urandom) : base + 16'(i);
            tick();
        end
        sample_valid = 0;
    endtask

    task automatic drain(input int n);
        rd_req = 1;
        repeat (n) tick();
        rd_req = 0;
    endtask

    initial begin
        rst_n       = 0;
        sample_data = '0;
        idle();
        repeat (3) tick();
        check("reset_level", 256'(level), 256'(0));
        check("reset_flags", 256'({ovf, unf, dcnt}), 256'(0));
        rst_n = 1;
        tick();

        // Ramp 0..31: word 0 visible one cycle after sample 15.
        for (int i = 0; i < 32; i++) begin
            sample_valid = 1;
            sample_data  = 16'(i);
            tick();
            if (i == 16) begin
                check("ramp_level1", 256'(level), 256'(1));
                check("ramp_w0_lo", 256'(rd_data[15:0]), 256'(0));
                check("ramp_w0_hi", 256'(rd_data[255:240]), 256'(16'h000F));
            end
        end
        sample_valid = 0;
        tick();
        check("ramp_level2", 256'(level), 256'(2));
        drain(2);

        // Partial word closed by flush, second flush is a no-op.
        feed(3, 0, 16'hA001);
        flush = 1;
        tick();
        flush = 0;
        tick();
        check("flush_level", 256'(level), 256'(1));
        check("flush_word", rd_data, {208'd0, 48'hA003A002A001});
        flush = 1;
        tick();
        flush = 0;
        repeat (2) tick();
        check("flush2_level", 256'(level), 256'(1));
        drain(1);

        // Fill to full, then one dropped word.
        feed(DEPTH * 16, 1, 0);
        tick();
        check("full_level", 256'(level), 256'(DEPTH));
        feed(16, 1, 0);
        tick();
        check("drop_ovf", 256'(ovf), 256'(1));
        check("drop_cnt1", 256'(dcnt), 256'(1));
        check("drop_level", 256'(level), 256'(DEPTH));
        clr = 1;
        tick();
        clr = 0;
        check("clr_flags", 256'({ovf, dcnt}), 256'(0));
        // Push landing on full with a same-cycle pop.
        feed(16, 1, 0);
        rd_req = 1;
        tick();
        rd_req = 0;
        check("swap_level", 256'(level), 256'(DEPTH));
        check("swap_nodrop", 256'({ovf, dcnt}), 256'(0));
        drain(DEPTH);
        check("drained", 256'(level), 256'(0));

        // Eight words out in order, ninth pop underflows.
        feed(8 * 16, 1, 0);
        tick();
        check("eight_level", 256'(level), 256'(8));
        drain(8);
        check("eight_empty", 256'(level), 256'(0));
        check("eight_nounf", 256'(unf), 256'(0));
        drain(1);
        check("ninth_unf", 256'(unf), 256'(1));
        check("ninth_level", 256'(level), 256'(0));

        // Asynchronous reset with 5 words stored and a partial word.
        feed(5 * 16 + 7, 1, 0);
        tick();
        check("pre_rst_level", 256'(level), 256'(5));
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        check("async_rst", 256'({level, ovf, unf, dcnt}), 256'(0));
        repeat (2) tick();
        rst_n = 1;
        tick();
        check("post_rst_level", 256'(level), 256'(0));
        feed(16, 1, 0);
        tick();
        tick();
        check("post_rst_one", 256'(level), 256'(1));
        drain(1);

        // Collisions at level 4 across 300 words (pointer wrap).
        feed(4 * 16, 1, 0);
        tick();
        for (int w = 0; w < 300; w++) begin
            for (int s = 0; s < 16; s++) begin
                sample_valid = 1;
                sample_data  = 16'($urandom);
                rd_req       = (s == 0 && w > 0);
                tick();
            end
        end
        sample_valid = 0;
        rd_req       = 1;
        tick();
        rd_req = 0;
        check("collide_level", 256'(level), 256'(4));
        drain(4);

        // Random mix of samples, flushes, pops and clears.
        for (int c = 0; c < 2000; c++) begin
            sample_valid = 1'($urandom_range(0, 1));
            sample_data  = 16'($urandom);
            flush        = ($urandom_range(0, 15) == 0);
            rd_req       = ($urandom_range(0, 7) == 0);
            clr          = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        flush = 1;
        tick();
        flush = 0;
        tick();
        drain(DEPTH + 4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
